sqrt_pipe_hs: RTL and testbench

Parametrised, fully pipelined unsigned integer square root with valid/ready handshaking, remainder output, optional round-to-nearest and a sideband tag. It sits in the RMS datapath between the mean-of-squares accumulator and the output formatter. It replaces the stall-only delay-line-plus-combinational square root with a one-result-bit-per-stage pipeline. That pipeline accepts one operand per cycle, applies backpressure to the accumulator, and carries a tag so that results can be matched to their channel.

---
 rtl/sqrt_pipe_hs.sv | 114 +++++++++++
 tb/tb_sqrt_pipe_hs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_pipe_hs.sv
// Fully pipelined unsigned integer square root, one root bit per stage, with
// valid/ready handshake, floor remainder, optional round-to-nearest and a sideband tag.
module sqrt_pipe_hs #(
    parameter int WIDTH = 16,
    parameter int ROUND = 0,
    parameter int TAG_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WIDTH-1:0]       in_a_i,
    input  logic [TAG_W-1:0]       in_tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [(WIDTH+1)/2-1:0] out_root_o,
    output logic [(WIDTH+1)/2:0]   out_rem_o,
    output logic [TAG_W-1:0]       out_tag_o
);
    localparam int N  = (WIDTH + 1) / 2;
    localparam int AW = 2 * N;

    // Element 0 is the first stage (S1), element N-1 the output stage (SN).
    logic [N-1:0]     vld_q, vld_d;
    logic [N-1:0]     root_q [N];
    logic [N+1:0]     rem_q  [N];
    logic [AW-1:0]    opnd_q [N];
    logic [TAG_W-1:0] tag_q  [N];
    logic [N-1:0]     root_d [N];
    logic [N+1:0]     rem_d  [N];
    logic [AW-1:0]    opnd_d [N];
    logic [TAG_W-1:0] tag_d  [N];

    logic [N-1:0]     src_root;
    logic [N+1:0]     src_rem;
    logic [AW-1:0]    src_opnd;
    logic [N+3:0]     trial_r, trial_t, diff;
    logic             advance;
    logic [N:0]       rem_fl;

    assign advance    = !vld_q[N-1] || out_ready_i;
    assign in_ready_o = advance;

    always_comb begin
        vld_d    = '0;
        root_d   = '{default: '0};
        rem_d    = '{default: '0};
        opnd_d   = '{default: '0};
        tag_d    = '{default: '0};
        src_root = '0;
        src_rem  = '0;
        src_opnd = '0;
        trial_r  = '0;
        trial_t  = '0;
        diff     = '0;
        for (int k = 0; k < N; k++) begin
            if (k == 0) begin
                src_root = '0;
                src_rem  = '0;
                src_opnd = AW'(in_a_i);
                vld_d[k] = in_valid_i;
                tag_d[k] = in_tag_i;
            end else begin
                src_root = root_q[k-1];
                src_rem  = rem_q[k-1];
                src_opnd = opnd_q[k-1];
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            // Restoring step on the operand bit pair owned by this stage.
            trial_r   = {src_rem, src_opnd[AW-2-2*k +: 2]};
            trial_t   = {2'b00, src_root, 2'b01};
            diff      = trial_r - trial_t;
            opnd_d[k] = src_opnd;
            if (trial_r >= trial_t) begin
                rem_d[k]  = diff[N+1:0];
                root_d[k] = (src_root << 1) | N'(1);
            end else begin
                rem_d[k]  = trial_r[N+1:0];
                root_d[k] = src_root << 1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < N; k++) begin
                root_q[k] <= '0;
                rem_q[k]  <= '0;
                opnd_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else if (advance) begin
            vld_q  <= vld_d;
            root_q <= root_d;
            rem_q  <= rem_d;
            opnd_q <= opnd_d;
            tag_q  <= tag_d;
        end
    end

    assign rem_fl      = rem_q[N-1][N:0];
    assign out_valid_o = vld_q[N-1];
    assign out_rem_o   = rem_fl;
    assign out_tag_o   = tag_q[N-1];

    // Round up when the remainder exceeds the root, saturating at all-ones.
    always_comb begin
        out_root_o = root_q[N-1];
        if (ROUND != 0 && rem_fl > {1'b0, root_q[N-1]} && root_q[N-1] != '1)
            out_root_o = root_q[N-1] + N'(1);
    end
endmodule

// File: tb/tb_sqrt_pipe_hs.sv
// Directed and randomised checks of sqrt_pipe_hs: latency, rounding, backpressure,
// bubbles, mid-stream reset and a reference-model comparison on random traffic.
module tb_sqrt_pipe_hs;
    localparam int NOPS = 1500;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // a: WIDTH=8 ROUND=0, b: WIDTH=8 ROUND=1, c: WIDTH=16 ROUND=0, d: WIDTH=7 ROUND=1
    logic       a_iv = 0, a_ir, a_ov, a_or = 1;
    logic [7:0] a_a = '0;
    logic [3:0] a_ti = '0, a_to, a_root;
    logic [4:0] a_rem;
    logic       b_iv = 0, b_ir, b_ov, b_or = 1;
    logic [7:0] b_a = '0;
    logic [3:0] b_ti = '0, b_to, b_root;
    logic [4:0] b_rem;
    logic        c_iv = 0, c_ir, c_ov, c_or = 1;
    logic [15:0] c_a = '0;
    logic [3:0]  c_ti = '0, c_to;
    logic [7:0]  c_root;
    logic [8:0]  c_rem;
    logic       d_iv = 0, d_ir, d_ov, d_or = 1;
    logic [6:0] d_a = '0;
    logic [3:0] d_ti = '0, d_to, d_root;
    logic [4:0] d_rem;

    sqrt_pipe_hs #(.WIDTH(8), .ROUND(0), .TAG_W(4)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_a_i(a_a),
        .in_tag_i(a_ti), .out_valid_o(a_ov), .out_ready_i(a_or), .out_root_o(a_root),
        .out_rem_o(a_rem), .out_tag_o(a_to));
    sqrt_pipe_hs #(.WIDTH(8), .ROUND(1), .TAG_W(4)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_a_i(b_a),
        .in_tag_i(b_ti), .out_valid_o(b_ov), .out_ready_i(b_or), .out_root_o(b_root),
        .out_rem_o(b_rem), .out_tag_o(b_to));
    sqrt_pipe_hs #(.WIDTH(16), .ROUND(0), .TAG_W(4)) u_c (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(c_iv), .in_ready_o(c_ir), .in_a_i(c_a),
        .in_tag_i(c_ti), .out_valid_o(c_ov), .out_ready_i(c_or), .out_root_o(c_root),
        .out_rem_o(c_rem), .out_tag_o(c_to));
    sqrt_pipe_hs #(.WIDTH(7), .ROUND(1), .TAG_W(4)) u_d (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(d_iv), .in_ready_o(d_ir), .in_a_i(d_a),
        .in_tag_i(d_ti), .out_valid_o(d_ov), .out_ready_i(d_or), .out_root_o(d_root),
        .out_rem_o(d_rem), .out_tag_o(d_to));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int isqrt(input int a);
        int r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    int t1_a [5] = '{0, 1, 2, 200, 255};
    int t1_r [5] = '{0, 1, 1, 14, 15};
    int t1_m [5] = '{0, 0, 1, 4, 30};
    int t2_a [4] = '{210, 211, 255, 224};
    int t2_r [4] = '{14, 15, 15, 15};
    int t2_m [4] = '{14, 15, 30, 28};
    int bp_a [8] = '{3, 17, 50, 99, 120, 144, 168, 250};
    int bp_r [8] = '{1, 4, 7, 9, 10, 12, 12, 15};
    int bp_m [8] = '{2, 1, 1, 18, 20, 0, 24, 25};
    int bub  [4] = '{1, 0, 0, 1};
    int rs_a [3] = '{250, 200, 17};

    int idx, oidx, snap_r, snap_m, snap_t;
    int c_qa[$], c_qt[$], d_qa[$], d_qt[$];
    int c_sent, c_got, d_sent, d_got, ea, et, fl, rm, er;
    bit c_acc, d_acc;

    initial begin
        #1 rst_i = 1'b1;
        #2;
        chk("rst_valid", a_ov, 0);
        chk("rst_ready", a_ir, 1);
        chk("rst_root", a_root, 0);
        chk("rst_rem", a_rem, 0);
        chk("rst_tag", a_to, 0);
        #14 rst_i = 1'b0;
        cyc();

        // back-to-back stream, latency N=4
        for (int c = 0; c < 11; c++) begin
            a_iv = (c < 5);
            if (c < 5) begin a_a = 8'(t1_a[c]); a_ti = 4'(c); end
            #1;
            if (c >= 4 && c < 9) begin
                chk("t1_valid", a_ov, 1);
                chk("t1_root", a_root, t1_r[c-4]);
                chk("t1_rem", a_rem, t1_m[c-4]);
                chk("t1_tag", a_to, c - 4);
            end else chk("t1_valid", a_ov, 0);
            cyc();
        end
        a_iv = 0;

        // rounding
        for (int c = 0; c < 9; c++) begin
            b_iv = (c < 4);
            if (c < 4) begin b_a = 8'(t2_a[c]); b_ti = 4'(c + 8); end
            #1;
            if (c >= 4 && c < 8) begin
                chk("rnd_valid", b_ov, 1);
                chk("rnd_root", b_root, t2_r[c-4]);
                chk("rnd_rem", b_rem, t2_m[c-4]);
                chk("rnd_tag", b_to, c + 4);
            end else chk("rnd_valid", b_ov, 0);
            cyc();
        end
        b_iv = 0;

        // backpressure: out_ready low for cycles 6..8
        idx = 0; oidx = 0;
        for (int c = 0; c < 40 && oidx < 8; c++) begin
            a_or = !(c >= 6 && c <= 8);
            a_iv = (idx < 8);
            if (idx < 8) begin a_a = 8'(bp_a[idx]); a_ti = 4'(idx); end
            #1;
            if (c == 6) begin snap_r = int'(a_root); snap_m = int'(a_rem); snap_t = int'(a_to); end
            if (c >= 6 && c <= 8) begin
                chk("bp_in_ready", a_ir, 0);
                chk("bp_stall_valid", a_ov, 1);
            end
            if (c == 7 || c == 8) begin
                chk("bp_hold_root", a_root, snap_r);
                chk("bp_hold_rem", a_rem, snap_m);
                chk("bp_hold_tag", a_to, snap_t);
            end
            if (c == 9) chk("bp_ready_back", a_ir, 1);
            if (a_ov && a_or) begin
                chk("bp_root", a_root, bp_r[oidx]);
                chk("bp_rem", a_rem, bp_m[oidx]);
                chk("bp_tag", a_to, oidx);
                oidx++;
            end
            if (a_iv && a_ir) idx++;
            cyc();
        end
        chk("bp_count", oidx, 8);
        a_iv = 0; a_or = 1;
        cyc();

        // bubbles
        for (int c = 0; c < 10; c++) begin
            a_iv = (c < 4) ? bub[c][0] : 1'b0;
            a_a  = 8'(100 + c); a_ti = 4'(c);
            #1;
            if (c >= 4 && c < 8) chk("bub_valid", a_ov, bub[c-4]);
            else chk("bub_valid", a_ov, 0);
            if (c == 7) begin
                chk("bub_root", a_root, 10);
                chk("bub_rem", a_rem, 3);
                chk("bub_tag", a_to, 3);
            end
            cyc();
        end
        a_iv = 0;

        // reset with three operands in flight, output stalled
        a_or = 0;
        for (int c = 0; c < 6; c++) begin
            a_iv = (c < 3);
            if (c < 3) begin a_a = 8'(rs_a[c]); a_ti = 4'(c + 5); end
            #1;
            cyc();
        end
        a_iv = 0;
        #1;
        chk("rs_pre_valid", a_ov, 1);
        chk("rs_pre_root", a_root, 15);
        rst_i = 1'b1;
        #1;
        chk("rs_valid", a_ov, 0);
        chk("rs_root", a_root, 0);
        chk("rs_rem", a_rem, 0);
        chk("rs_tag", a_to, 0);
        chk("rs_ready", a_ir, 1);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        a_or = 1;
        cyc();
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rs_no_stale", a_ov, 0);
            cyc();
        end
        for (int c = 0; c < 6; c++) begin
            a_iv = (c == 0); a_a = 8'd200; a_ti = 4'd9;
            #1;
            if (c == 4) begin
                chk("rs_after_valid", a_ov, 1);
                chk("rs_after_root", a_root, 14);
                chk("rs_after_rem", a_rem, 4);
                chk("rs_after_tag", a_to, 9);
            end else chk("rs_after_valid", a_ov, 0);
            cyc();
        end
        a_iv = 0;

        // random traffic against a brute-force reference
        c_sent = 0; c_got = 0; d_sent = 0; d_got = 0; c_acc = 0; d_acc = 0;
        for (int cy = 0; cy < 20000 && (c_got < NOPS || d_got < NOPS); cy++) begin
            if (c_acc) c_iv = 0;
            if (d_acc) d_iv = 0;
            c_acc = 0; d_acc = 0;
            if (!c_iv && c_sent < NOPS && $urandom_range(3) != 0) begin
                c_iv = 1; c_a = 16'($urandom); c_ti = 4'(c_sent);
            end
            if (!d_iv && d_sent < NOPS && $urandom_range(3) != 0) begin
                d_iv = 1; d_a = 7'($urandom); d_ti = 4'(d_sent);
            end
            c_or = ($urandom_range(3) != 0);
            d_or = ($urandom_range(3) != 0);
            #1;
            if (c_ov && c_or) begin
                if (c_qa.size() == 0) chk("r16_spurious", c_ov, 0);
                else begin
                    ea = c_qa.pop_front(); et = c_qt.pop_front();
                    fl = isqrt(ea);
                    chk("r16_root", c_root, fl);
                    chk("r16_rem", c_rem, ea - fl * fl);
                    chk("r16_tag", c_to, et);
                    c_got++;
                end
            end
            if (d_ov && d_or) begin
                if (d_qa.size() == 0) chk("r7_spurious", d_ov, 0);
                else begin
                    ea = d_qa.pop_front(); et = d_qt.pop_front();
                    fl = isqrt(ea);
                    rm = ea - fl * fl;
                    er = (rm > fl && fl != 15) ? fl + 1 : fl;
                    chk("r7_root", d_root, er);
                    chk("r7_rem", d_rem, rm);
                    chk("r7_tag", d_to, et);
                    d_got++;
                end
            end
            if (c_iv && c_ir) begin
                c_qa.push_back(int'(c_a)); c_qt.push_back(int'(c_ti)); c_sent++; c_acc = 1;
            end
            if (d_iv && d_ir) begin
                d_qa.push_back(int'(d_a)); d_qt.push_back(int'(d_ti)); d_sent++; d_acc = 1;
            end
            cyc();
        end
        chk("r16_count", c_got, NOPS);
        chk("r7_count", d_got, NOPS);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
